// File: rtl/matrix_store_ctrl.sv
// Matrix store: staged row-major writes committed atomically into a slot pool
// bucketed by (rows,cols); reads stream one bucket ordinal. Option: MATRIX_STORE_OVERWRITE_EN.
module matrix_store_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_SIZE     = 5,
  parameter int MATRIX_NUM   = 8,
  parameter int MAX_PER_SIZE = 4,
  localparam int SLOT_W = (MATRIX_NUM > 1) ? $clog2(MATRIX_NUM) : 1,
  localparam int ORD_W  = $clog2(MAX_PER_SIZE + 1),
  localparam int RIDX_W = (ORD_W > 1) ? ORD_W - 1 : 1,
  localparam int UC_W   = $clog2(MATRIX_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  idle_o,
  input  logic                  wr_start_i,
  input  logic [2:0]            wr_row_i,
  input  logic [2:0]            wr_col_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_done_o,
  output logic                  wr_err_o,
  output logic [SLOT_W-1:0]     wr_slot_o,
  input  logic                  rd_req_i,
  input  logic [2:0]            rd_row_i,
  input  logic [2:0]            rd_col_i,
  input  logic [RIDX_W-1:0]     rd_idx_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  rd_err_o,
  output logic [2:0]            rd_dim_row_o,
  output logic [2:0]            rd_dim_col_o,
  input  logic [2:0]            cnt_row_i,
  input  logic [2:0]            cnt_col_i,
  output logic [ORD_W-1:0]      cnt_out_o,
  output logic [UC_W-1:0]       used_cnt_o
);
  localparam int NE    = MAX_SIZE * MAX_SIZE;
  localparam int CNT_W = $clog2(NE + 1);
  localparam int BK_W  = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [2:0]       MAXS = 3'(MAX_SIZE);
  localparam logic [ORD_W-1:0] MAXP = ORD_W'(MAX_PER_SIZE);

  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_COMMIT = 2'd2, S_RD = 2'd3;

  function automatic logic dims_ok(input logic [2:0] r, input logic [2:0] c);
    return (r != 3'd0) && (r <= MAXS) && (c != 3'd0) && (c <= MAXS);
  endfunction

  function automatic logic [BK_W-1:0] bidx(input logic [2:0] r, input logic [2:0] c);
    return BK_W'((int'(r) - 1) * MAX_SIZE + int'(c) - 1);
  endfunction

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] mem_q   [MATRIX_NUM][NE];
  logic [DATA_WIDTH-1:0] stage_q [NE];
  logic [SLOT_W-1:0]     list_q  [NE][MAX_PER_SIZE];
  logic [ORD_W-1:0]      bcnt_q  [NE];
  logic [MATRIX_NUM-1:0] used_q;
  logic [UC_W-1:0]       used_cnt_q;
  logic [2:0]            w_row_q, w_col_q, rd_row_q, rd_col_q;
  logic [CNT_W-1:0]      w_n_q, w_elem_q, rd_n_q, rd_elem_q;
  logic [SLOT_W-1:0]     rd_slot_q, wr_slot_q;
  logic [ORD_W-1:0]      cnt_q;
  logic                  wr_done_q, wr_err_q, rd_err_q;

  logic [BK_W-1:0]   wb, rb;
  logic              free_found, cm_ok, cm_evict;
  logic [SLOT_W-1:0] free_slot, cm_slot;

  assign wb = bidx(w_row_q, w_col_q);
  assign rb = bidx(rd_row_i, rd_col_i);

  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = MATRIX_NUM - 1; i >= 0; i--) begin
      if (!used_q[i]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  // Commit decision: append into a free slot, or (optionally) recycle the bucket's oldest slot.
  always_comb begin
    cm_ok    = 1'b0;
    cm_evict = 1'b0;
    cm_slot  = free_slot;
    if (bcnt_q[wb] != MAXP) begin
      cm_ok = free_found;
    end else begin
`ifdef MATRIX_STORE_OVERWRITE_EN
      cm_ok    = 1'b1;
      cm_evict = 1'b1;
      cm_slot  = list_q[wb][0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_FILL && wr_valid_i) stage_q[w_elem_q] <= wr_data_i;
      if (state_q == S_COMMIT && cm_ok) begin
        for (int e = 0; e < NE; e++) mem_q[cm_slot][e] <= stage_q[e];
        if (cm_evict) begin
          for (int k = 0; k < MAX_PER_SIZE - 1; k++) list_q[wb][k] <= list_q[wb][k+1];
          list_q[wb][MAX_PER_SIZE-1] <= cm_slot;
        end else begin
          list_q[wb][bcnt_q[wb]] <= cm_slot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      used_q     <= '0;
      used_cnt_q <= '0;
      for (int b = 0; b < NE; b++) bcnt_q[b] <= '0;
      w_row_q    <= '0;
      w_col_q    <= '0;
      w_n_q      <= '0;
      w_elem_q   <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      rd_n_q     <= '0;
      rd_elem_q  <= '0;
      rd_slot_q  <= '0;
      wr_slot_q  <= '0;
      cnt_q      <= '0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      cnt_q     <= dims_ok(cnt_row_i, cnt_col_i) ? bcnt_q[bidx(cnt_row_i, cnt_col_i)] : '0;
      case (state_q)
        S_IDLE: begin
          if (wr_start_i) begin
            if (dims_ok(wr_row_i, wr_col_i)) begin
              w_row_q  <= wr_row_i;
              w_col_q  <= wr_col_i;
              w_n_q    <= CNT_W'(wr_row_i) * CNT_W'(wr_col_i);
              w_elem_q <= '0;
              state_q  <= S_FILL;
            end else begin
              wr_err_q <= 1'b1;
            end
          end else if (rd_req_i) begin
            if (dims_ok(rd_row_i, rd_col_i) && (ORD_W'(rd_idx_i) < bcnt_q[rb])) begin
              rd_slot_q <= list_q[rb][rd_idx_i];
              rd_row_q  <= rd_row_i;
              rd_col_q  <= rd_col_i;
              rd_n_q    <= CNT_W'(rd_row_i) * CNT_W'(rd_col_i);
              rd_elem_q <= '0;
              state_q   <= S_RD;
            end else begin
              rd_err_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (wr_valid_i) begin
            if (w_elem_q == w_n_q - CNT_W'(1)) state_q <= S_COMMIT;
            else w_elem_q <= w_elem_q + CNT_W'(1);
          end
        end
        S_COMMIT: begin
          if (cm_ok) begin
            wr_done_q <= 1'b1;
            wr_slot_q <= cm_slot;
            if (!cm_evict) begin
              used_q[cm_slot] <= 1'b1;
              used_cnt_q      <= used_cnt_q + UC_W'(1);
              bcnt_q[wb]      <= bcnt_q[wb] + ORD_W'(1);
            end
          end else begin
            wr_err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          if (rd_ready_i) begin
            if (rd_last_o) state_q <= S_IDLE;
            else rd_elem_q <= rd_elem_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign idle_o       = (state_q == S_IDLE);
  assign wr_ready_o   = (state_q == S_FILL);
  assign rd_valid_o   = (state_q == S_RD);
  assign rd_data_o    = rd_valid_o ? mem_q[rd_slot_q][rd_elem_q] : '0;
  assign rd_last_o    = rd_valid_o && (rd_elem_q == rd_n_q - CNT_W'(1));
  assign rd_dim_row_o = rd_row_q;
  assign rd_dim_col_o = rd_col_q;
  assign wr_done_o    = wr_done_q;
  assign wr_err_o     = wr_err_q;
  assign wr_slot_o    = wr_slot_q;
  assign rd_err_o     = rd_err_q;
  assign cnt_out_o    = cnt_q;
  assign used_cnt_o   = used_cnt_q;
endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Directed bench for matrix_store_ctrl; expectations adapt to MATRIX_STORE_OVERWRITE_EN.
module tb_matrix_store_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, idle, wr_start, wr_valid, wr_ready, wr_done, wr_err;
  logic [2:0] wr_row, wr_col, wr_slot, rd_row, rd_col, rd_dim_row, rd_dim_col;
  logic [2:0] cnt_row, cnt_col, cnt_out;
  logic [7:0] wr_data, rd_data;
  logic       rd_req, rd_valid, rd_ready, rd_last, rd_err;
  logic [1:0] rd_idx;
  logic [3:0] used_cnt;

  matrix_store_ctrl dut (
    .clk(clk), .rst(rst), .idle_o(idle),
    .wr_start_i(wr_start), .wr_row_i(wr_row), .wr_col_i(wr_col),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .wr_done_o(wr_done), .wr_err_o(wr_err), .wr_slot_o(wr_slot),
    .rd_req_i(rd_req), .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .rd_last_o(rd_last), .rd_err_o(rd_err),
    .rd_dim_row_o(rd_dim_row), .rd_dim_col_o(rd_dim_col),
    .cnt_row_i(cnt_row), .cnt_col_i(cnt_col), .cnt_out_o(cnt_out),
    .used_cnt_o(used_cnt)
  );

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] wbuf [64];
  logic [7:0] rbuf [256];
  logic       rlast [256];
  logic [2:0] dim_r, dim_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] r, input logic [2:0] c, input int n,
                          output logic done, output logic err, output logic [2:0] slot);
    wr_start = 1'b1; wr_row = r; wr_col = c;
    @(negedge clk);
    wr_start = 1'b0;
    chk("wr_ready_up", 32'(wr_ready), 32'd1);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1; wr_data = wbuf[k];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("commit_quiet", 32'({wr_done, wr_err, idle}), 32'd0);
    @(negedge clk);
    done = wr_done; err = wr_err; slot = wr_slot;
    chk("idle_after_commit", 32'(idle), 32'd1);
  endtask

  task automatic do_read(input logic [2:0] r, input logic [2:0] c, input logic [1:0] idx,
                         input bit tog, output int n, output logic err);
    bit ph, stalled, fin;
    logic [7:0] held;
    rd_req = 1'b1; rd_row = r; rd_col = c; rd_idx = idx;
    @(negedge clk);
    rd_req = 1'b0;
    err = rd_err; n = 0; ph = 1'b1; stalled = 1'b0; fin = 1'b0; held = '0;
    dim_r = rd_dim_row; dim_c = rd_dim_col;
    if (!err) begin
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
        if (!rd_valid) fin = 1'b1;
        else begin
          if (stalled) chk("rd_hold", 32'(rd_data), 32'(held));
          rd_ready = tog ? ph : 1'b1;
          ph = !ph;
          if (rd_ready) begin
            rbuf[n] = rd_data; rlast[n] = rd_last; n++; fin = rd_last;
          end else held = rd_data;
          stalled = !rd_ready;
          @(negedge clk);
        end
      end
      rd_ready = 1'b0;
    end
  endtask

  task automatic chk_stream(input string tag, input int n, input int exp_n, input int base);
    chk({tag, "_len"}, 32'(n), 32'(exp_n));
    for (int k = 0; k < exp_n && k < n; k++) begin
      chk($sformatf("%s_d%0d", tag, k), 32'(rbuf[k]), 32'(wbuf[base + k]));
      chk($sformatf("%s_last%0d", tag, k), 32'(rlast[k]), 32'(k == exp_n - 1));
    end
  endtask

  logic done, err;
  logic [2:0] slot;
  int n;

  initial begin
    rst = 1'b1; wr_start = 0; wr_row = 0; wr_col = 0; wr_valid = 0; wr_data = 0;
    rd_req = 0; rd_row = 0; rd_col = 0; rd_idx = 0; rd_ready = 0;
    cnt_row = 3'd2; cnt_col = 3'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_outs", 32'({wr_ready, rd_valid, rd_last, wr_done, wr_err, rd_err}), 32'd0);
    chk("rst_used", 32'(used_cnt), 32'd0);
    chk("rst_cnt", 32'(cnt_out), 32'd0);
    chk("rst_misc", 32'({wr_slot, rd_dim_row, rd_dim_col, rd_data}), 32'd0);

    // 2x3 write and plain read; slots 32.. of wbuf keep a reference copy
    wbuf[0] = 8'd1; wbuf[1] = 8'd2; wbuf[2] = 8'hFB; wbuf[3] = 8'd4; wbuf[4] = 8'd5; wbuf[5] = 8'd6;
    for (int k = 0; k < 6; k++) wbuf[32 + k] = wbuf[k];
    do_write(3'd2, 3'd3, 6, done, err, slot);
    chk("w23_done", 32'({done, err}), 32'b10);
    chk("w23_slot", 32'(slot), 32'd0);
    chk("w23_used", 32'(used_cnt), 32'd1);
    chk("w23_cnt_lag", 32'(cnt_out), 32'd0);
    @(negedge clk);
    chk("w23_done_pulse", 32'(wr_done), 32'd0);
    chk("w23_cnt", 32'(cnt_out), 32'd1);
    do_read(3'd2, 3'd3, 2'd0, 1'b0, n, err);
    chk("r23_err", 32'(err), 32'd0);
    chk("r23_dims", 32'({dim_r, dim_c}), 32'({3'd2, 3'd3}));
    chk_stream("r23", n, 6, 32);
    chk("r23_end", 32'({idle, rd_valid}), 32'b10);
    do_read(3'd2, 3'd3, 2'd0, 1'b1, n, err);
    chk("r23t_err", 32'(err), 32'd0);
    chk_stream("r23t", n, 6, 32);

    // four 2x2 fill the bucket; fifth hits the full-bucket policy
    cnt_row = 3'd2; cnt_col = 3'd2;
    for (int m = 0; m < 5; m++) begin
      for (int k = 0; k < 4; k++) begin
        wbuf[k] = 8'(16 * (m + 1) + k);
        wbuf[40 + 4 * m + k] = wbuf[k];
      end
      do_write(3'd2, 3'd2, 4, done, err, slot);
      if (m < 4) begin
        chk($sformatf("w22_%0d_done", m), 32'({done, err}), 32'b10);
        chk($sformatf("w22_%0d_slot", m), 32'(slot), 32'(m + 1));
      end
    end
`ifdef MATRIX_STORE_OVERWRITE_EN
    chk("w22_5_done", 32'({done, err}), 32'b10);
    chk("w22_5_slot", 32'(slot), 32'd1);
`else
    chk("w22_5_err", 32'({done, err}), 32'b01);
`endif
    @(negedge clk);
    chk("w22_err_pulse", 32'(wr_err), 32'd0);
    chk("w22_cnt", 32'(cnt_out), 32'd4);
    chk("w22_used", 32'(used_cnt), 32'd5);
    do_read(3'd2, 3'd2, 2'd3, 1'b0, n, err);
    chk("r22i3_err", 32'(err), 32'd0);
`ifdef MATRIX_STORE_OVERWRITE_EN
    chk_stream("r22i3", n, 4, 56);
`else
    chk_stream("r22i3", n, 4, 52);
`endif
    do_read(3'd2, 3'd2, 2'd0, 1'b0, n, err);
`ifdef MATRIX_STORE_OVERWRITE_EN
    chk_stream("r22i0", n, 4, 44);
`else
    chk_stream("r22i0", n, 4, 40);
`endif

    // exhaust the pool with 1x1 writes
    for (int m = 0; m < 4; m++) begin
      wbuf[0] = 8'(7 + m);
      do_write(3'd1, 3'd1, 1, done, err, slot);
      if (m < 3) begin
        chk($sformatf("w11_%0d_done", m), 32'({done, err}), 32'b10);
        chk($sformatf("w11_%0d_slot", m), 32'(slot), 32'(5 + m));
      end else chk("w11_full_err", 32'({done, err}), 32'b01);
    end
    chk("pool_used", 32'(used_cnt), 32'd8);

    // illegal dims rejected in the next cycle without leaving IDLE
    wr_start = 1'b1; wr_row = 3'd0; wr_col = 3'd3;
    @(negedge clk);
    wr_start = 1'b0;
    chk("w03_err", 32'({wr_err, idle, wr_ready}), 32'b110);
    @(negedge clk);
    chk("w03_pulse", 32'(wr_err), 32'd0);
    wr_start = 1'b1; wr_row = 3'd6; wr_col = 3'd1;
    @(negedge clk);
    wr_start = 1'b0;
    chk("w61_err", 32'({wr_err, idle}), 32'b11);

    // write wins over a simultaneous read
    wr_start = 1'b1; wr_row = 3'd3; wr_col = 3'd3;
    rd_req = 1'b1; rd_row = 3'd2; rd_col = 3'd3; rd_idx = 2'd0;
    @(negedge clk);
    wr_start = 1'b0; rd_req = 1'b0;
    chk("pri_wr", 32'({wr_ready, rd_valid, rd_err}), 32'b100);
    for (int k = 0; k < 9; k++) begin
      wr_valid = 1'b1; wr_data = 8'(k);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("pri_rd_none", 32'({rd_valid, rd_err}), 32'd0);
    @(negedge clk);
    chk("w33_nofree", 32'({wr_done, wr_err}), 32'b01);
    chk("w33_used", 32'(used_cnt), 32'd8);

    do_read(3'd3, 3'd3, 2'd0, 1'b0, n, err);
    chk("r33_empty", 32'({err, rd_valid}), 32'b10);
    do_read(3'd2, 3'd3, 2'd1, 1'b0, n, err);
    chk("r23_idx1", 32'(err), 32'd1);
    @(negedge clk);
    chk("rd_err_pulse", 32'(rd_err), 32'd0);

    // reset in the middle of a 3x3 write
    wr_start = 1'b1; wr_row = 3'd3; wr_col = 3'd3;
    @(negedge clk);
    wr_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_data = 8'(k);
      @(negedge clk);
    end
    wr_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_idle", 32'({idle, wr_ready}), 32'b10);
    chk("mrst_used", 32'(used_cnt), 32'd0);
    do_read(3'd2, 3'd3, 2'd0, 1'b0, n, err);
    chk("mrst_rd_err", 32'(err), 32'd1);
    cnt_row = 3'd2; cnt_col = 3'd3;
    @(negedge clk);
    chk("mrst_cnt", 32'(cnt_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
